// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared constants, bus widths and FSM encoding for the UART boot loader.
// UART_LOADER_CHECKSUM_EN adds the CSUM state.
package uart_loader_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {
    SYNC, LEN0, LEN1, DATA, WRITE, DONE
`ifdef UART_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;
endpackage

// File: rtl/uart_loader_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-FF synchroniser, mid-bit sampling, glitch reject and framing check.
module uart_rx_core #(
  parameter int CLK_DIV = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);
  localparam int CW = $clog2(CLK_DIV);
  logic [2:0]    sync;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    sh;
  // sync[1] is the synchronised line, sync[2] its previous value for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync        <= 3'b111;
      busy        <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync        <= {sync[1:0], i_rx};
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (!busy) begin
        if (sync[2] && !sync[1]) begin
          busy    <= 1'b1;
          cnt     <= CW'(CLK_DIV / 2 - 1);
          bit_idx <= '0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt     <= CW'(CLK_DIV - 1);
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd0 && sync[1]) begin
          busy <= 1'b0;
        end else if (bit_idx == 4'd9) begin
          busy        <= 1'b0;
          o_valid     <= sync[1];
          o_frame_err <= !sync[1];
          o_data      <= sh;
        end else if (bit_idx != 4'd0) begin
          sh <= {sync[1], sh[7:1]};
        end
      end
    end
  end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: UART boot loader writing a framed image into BRAM, holding the CPU in reset until done.
// Define UART_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int          CLK_DIV   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 8192,
  parameter int          TIMEOUT   = 65536
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic [STRB_W-1:0] o_wr,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_err
);
  logic [7:0]        rx_data;
  logic              rx_valid, rx_ferr;
  state_t            state, state_d;
  logic [15:0]       len, len_d, wcnt, wcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        bcnt, bcnt_d;
  logic [31:0]       idle, idle_d;
  logic [7:0]        csum, csum_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic [STRB_W-1:0] wr_d;
  logic              cpu_rst_d, done_d, err_d, counting, timeout, abort, fin;

  uart_rx_core #(.CLK_DIV(CLK_DIV)) u_rx (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx       (i_rx),
    .o_data     (rx_data),
    .o_valid    (rx_valid),
    .o_frame_err(rx_ferr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= SYNC;
      len       <= '0;
      wcnt      <= '0;
      asm_q     <= '0;
      bcnt      <= '0;
      idle      <= '0;
      csum      <= '0;
      o_addr    <= BASE_ADDR;
      o_data    <= '0;
      o_wr      <= '0;
      o_cpu_rst <= 1'b1;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state     <= state_d;
      len       <= len_d;
      wcnt      <= wcnt_d;
      asm_q     <= asm_d;
      bcnt      <= bcnt_d;
      idle      <= idle_d;
      csum      <= csum_d;
      o_addr    <= addr_d;
      o_data    <= data_d;
      o_wr      <= wr_d;
      o_cpu_rst <= cpu_rst_d;
      o_done    <= done_d;
      o_err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    len_d     = len;
    wcnt_d    = wcnt;
    asm_d     = asm_q;
    bcnt_d    = bcnt;
    csum_d    = csum;
    addr_d    = o_addr;
    data_d    = o_data;
    wr_d      = '0;
    cpu_rst_d = o_cpu_rst;
    done_d    = o_done;
    err_d     = 1'b0;
    fin       = 1'b0;
    counting  = state != SYNC && state != DONE && state != WRITE;
    // a byte arriving on the timeout cycle wins
    timeout   = counting && !rx_valid && idle == 32'(TIMEOUT - 1);
    idle_d    = (rx_valid || !counting) ? '0 : idle + 32'd1;
    abort     = state != SYNC && state != DONE && (rx_ferr || timeout);
    case (state)
      SYNC, DONE: if (rx_valid && rx_data == SYNC_BYTE) begin
        state_d   = LEN0;
        cpu_rst_d = 1'b1;
        done_d    = 1'b0;
        csum_d    = '0;
      end
      LEN0: if (rx_valid) begin
        len_d[7:0] = rx_data;
        csum_d     = csum + rx_data;
        state_d    = LEN1;
      end
      LEN1: if (rx_valid) begin
        len_d[15:8] = rx_data;
        csum_d      = csum + rx_data;
        if ({rx_data, len[7:0]} == 16'd0) begin
          fin = 1'b1;
        end else if ({16'd0, rx_data, len[7:0]} > 32'(MEM_WORDS)) begin
          err_d   = 1'b1;
          state_d = SYNC;
        end else begin
          state_d = DATA;
          wcnt_d  = '0;
          bcnt_d  = '0;
          addr_d  = BASE_ADDR;
        end
      end
      // bytes enter at the top so after three bytes asm_q holds {b2, b1, b0}
      DATA: if (rx_valid) begin
        csum_d = csum + rx_data;
        bcnt_d = bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          data_d  = {rx_data, asm_q};
          wr_d    = '1;
          state_d = WRITE;
        end else begin
          asm_d = {rx_data, asm_q[23:8]};
        end
      end
      WRITE: begin
        addr_d = o_addr + 32'd4;
        wcnt_d = wcnt + 16'd1;
        if (wcnt + 16'd1 == len) fin = 1'b1;
        else state_d = DATA;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      CSUM: if (rx_valid) begin
        if (rx_data == csum) begin
          state_d   = DONE;
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          state_d = SYNC;
          err_d   = 1'b1;
        end
      end
`endif
      default: state_d = SYNC;
    endcase
    if (fin) begin
`ifdef UART_LOADER_CHECKSUM_EN
      state_d = CSUM;
`else
      state_d   = DONE;
      cpu_rst_d = 1'b0;
      done_d    = 1'b1;
`endif
    end
    if (abort) begin
      state_d = SYNC;
      err_d   = 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed and randomized frames against a queue-based model of the loaded image.
`timescale 1ns/1ps
module tb_uart_loader;
  localparam int          CLK_DIV   = 4;
  localparam int          MEM_WORDS = 4;
  localparam int          TIMEOUT   = 200;
  localparam logic [31:0] BASE      = 32'h0;

  logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [31:0] addr, data;
  logic [3:0]  wr;
  logic        cpu_rst, done, err;
  int          checks = 0, errors = 0, err_seen = 0;
  logic [63:0] got[$], exp_q[$];
  logic [7:0]  fr[$];
  logic        prev_wr = 1'b0, prev_err = 1'b0;

  uart_loader #(
    .CLK_DIV  (CLK_DIV),
    .BASE_ADDR(BASE),
    .MEM_WORDS(MEM_WORDS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_rx     (rx),
    .o_addr   (addr),
    .o_data   (data),
    .o_wr     (wr),
    .o_cpu_rst(cpu_rst),
    .o_done   (done),
    .o_err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (wr !== 4'h0) begin
      got.push_back({addr, data});
      chk("wr_strobe", {60'd0, wr}, 64'hF);
      chk("wr_one_cycle", {63'd0, prev_wr}, 64'd0);
      chk("wr_addr_ok", {63'd0, addr[1:0] == 2'b00 && addr <= BASE + 32'(4 * (MEM_WORDS - 1))}, 64'd1);
    end
    if (err === 1'b1) begin
      err_seen++;
      chk("err_one_cycle", {63'd0, prev_err}, 64'd0);
    end
    prev_wr  = (wr !== 4'h0);
    prev_err = (err === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_q();
    foreach (fr[i]) send_byte(fr[i], 1'b1);
  endtask

  // model: a frame of len random words loads word i at BASE+4i; oversize frames load nothing
  task automatic make_frame(input int len);
    logic [7:0]  s;
    logic [31:0] w;
    logic [15:0] l;
    l = 16'(len);
    fr.push_back(8'hA5);
    fr.push_back(l[7:0]);
    fr.push_back(l[15:8]);
    s = l[7:0] + l[15:8];
    if (len > MEM_WORDS) return;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      exp_q.push_back({BASE + 32'(4 * i), w});
      for (int k = 0; k < 4; k++) begin
        fr.push_back(w[8*k +: 8]);
        s = s + w[8*k +: 8];
      end
    end
`ifdef UART_LOADER_CHECKSUM_EN
    fr.push_back(s);
`endif
  endtask

  task automatic finish_check(input string tag, input int exp_err, input logic exp_done);
    repeat (4 * CLK_DIV) @(negedge clk);
    chk({tag, "_nwrites"}, 64'(got.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) if (i < got.size()) chk({tag, "_write"}, got[i], exp_q[i]);
    chk({tag, "_err"}, 64'(err_seen), 64'(exp_err));
    chk({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
    chk({tag, "_cpu_rst"}, {63'd0, cpu_rst}, {63'd0, !exp_done});
    got.delete();
    exp_q.delete();
    fr.delete();
    err_seen = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, junk;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk("rst_addr", {32'd0, addr}, {32'd0, BASE});
    chk("rst_data", {32'd0, data}, 64'd0);
    chk("rst_wr", {60'd0, wr}, 64'd0);
    chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    rst_n = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    fr    = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef UART_LOADER_CHECKSUM_EN
    fr.push_back(8'h4E);
`endif
    exp_q = '{{32'h0, 32'h12345678}, {32'h4, 32'hDEADBEEF}};
    send_q();
    finish_check("load2", 0, 1'b1);
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
`ifdef UART_LOADER_CHECKSUM_EN
    fr.push_back(8'h00);
`endif
    send_q();
    finish_check("len0", 0, 1'b1);
    send_byte(8'hA5, 1'b1);
    chk("rehold_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rehold_done", {63'd0, done}, 64'd0);
    fr = '{8'h02, 8'h00, 8'h11, 8'h22};
    send_q();
    chk("to_early", 64'(err_seen), 64'd0);
    repeat (TIMEOUT + 20) @(negedge clk);
    finish_check("timeout", 1, 1'b0);
    make_frame(3);
    send_q();
    finish_check("after_to", 0, 1'b1);
    fr = '{8'hA5, 8'h01, 8'h00};
    send_q();
    send_byte(8'hAA, 1'b0);
    finish_check("ferr", 1, 1'b0);
    send_byte(8'h5A, 1'b0);
    finish_check("ferr_sync", 0, 1'b0);
    make_frame(5);
    send_q();
    finish_check("len_over", 1, 1'b0);
    make_frame(4);
    send_q();
    finish_check("len_max", 0, 1'b1);
    for (int r = 0; r < 6; r++) begin
      len  = $urandom_range(0, 5);
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom);
        fr.push_back(b == 8'hA5 ? 8'h3C : b);
      end
      make_frame(len);
      send_q();
      finish_check("rand", (len > MEM_WORDS) ? 1 : 0, len <= MEM_WORDS);
    end
`ifdef UART_LOADER_CHECKSUM_EN
    fr    = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    exp_q = '{{BASE, 32'h04030201}};
    send_q();
    finish_check("csum_ok", 0, 1'b1);
    fr    = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0C};
    exp_q = '{{BASE, 32'h04030201}};
    send_q();
    finish_check("csum_bad", 1, 1'b0);
`endif
    fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_q();
    chk("pre_rst_writes", 64'(got.size()), 64'd1);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", {32'd0, addr}, {32'd0, BASE});
    chk("async_rst_data", {32'd0, data}, 64'd0);
    chk("async_rst_wr", {60'd0, wr}, 64'd0);
    chk("async_rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    got.delete();
    fr.delete();
    err_seen = 0;
    make_frame(2);
    send_q();
    finish_check("post_rst", 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
